// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// A grant stage picks at most one requester per cycle, an issue stage
// registers the winning operation and drives the ALU, and a response stage
// captures the ALU result into the winner's response registers.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high; the requester holds valid and payload until then.
// reqN_ready depends only on the valids, the priority pointer and reset.
// Responses have no ready: rspN_valid is a one-cycle pulse that must be taken.
module alu_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,

    output logic        rsp0_valid,
    output logic [31:0] rsp0_out,
    output logic        rsp0_equal,

    output logic        rsp1_valid,
    output logic [31:0] rsp1_out,
    output logic        rsp1_equal,

    output logic [3:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_out,
    input  logic        alu_equal
);

    // Grant decision for this cycle.
    logic        grant0;
    logic        grant1;
    // Completed handshakes at the coming edge.
    logic        hs0;
    logic        hs1;
    logic        hs_any;
    // Priority pointer: 1 means requester 1 was granted most recently, so
    // requester 0 wins the next contended cycle. Reset value favours req0.
    logic        last_grant;
    // Issue stage bookkeeping.
    logic        iss_valid;
    logic        iss_id;
    // Payload of the winning requester, selected ahead of the issue register.
    logic [3:0]  sel_op;
    logic [31:0] sel_in1;
    logic [31:0] sel_in2;

    // Arbitration: a lone requester always wins; contention is resolved by
    // the fixed priority or by the round-robin pointer. Nothing is granted
    // while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                if (FIXED_PRIO != 0) begin
                    grant0 = 1'b1;
                end else if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign hs0        = req0_valid & grant0;
    assign hs1        = req1_valid & grant1;
    assign hs_any     = hs0 | hs1;

    // Payload mux feeding the issue register.
    always_comb begin
        sel_op  = req0_op;
        sel_in1 = req0_in1;
        sel_in2 = req0_in2;
        if (hs1) begin
            sel_op  = req1_op;
            sel_in1 = req1_in1;
            sel_in2 = req1_in2;
        end
    end

    // Round-robin pointer moves only when a handshake actually completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (hs_any) begin
            last_grant <= hs1;
        end
    end

    // Issue stage: register the winning operation; ALU inputs hold their
    // last values in cycles without a new issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_id    <= 1'b0;
            alu_op    <= 4'd0;
            alu_in1   <= 32'd0;
            alu_in2   <= 32'd0;
        end else begin
            iss_valid <= hs_any;
            if (hs_any) begin
                iss_id  <= hs1;
                alu_op  <= sel_op;
                alu_in1 <= sel_in1;
                alu_in2 <= sel_in2;
            end
        end
    end

    // Response stage for requester 0: capture the ALU result when the issued
    // operation belongs to it, otherwise hold the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_out   <= 32'd0;
            rsp0_equal <= 1'b0;
        end else begin
            rsp0_valid <= iss_valid && !iss_id;
            if (iss_valid && !iss_id) begin
                rsp0_out   <= alu_out;
                rsp0_equal <= alu_equal;
            end
        end
    end

    // Response stage for requester 1, mirror of requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_out   <= 32'd0;
            rsp1_equal <= 1'b0;
        end else begin
            rsp1_valid <= iss_valid && iss_id;
            if (iss_valid && iss_id) begin
                rsp1_out   <= alu_out;
                rsp1_equal <= alu_equal;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter. Two instances share the
// request inputs: dut_rr (round-robin) and dut_fp (fixed priority). Each has
// its own combinational ALU model.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLT = 4'h5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared request inputs ----------------
    logic        req0_valid;
    logic [3:0]  req0_op;
    logic [31:0] req0_in1;
    logic [31:0] req0_in2;
    logic        req1_valid;
    logic [3:0]  req1_op;
    logic [31:0] req1_in1;
    logic [31:0] req1_in2;

    // ---------------- round-robin instance ----------------
    logic        a_req0_ready, a_req1_ready;
    logic        a_rsp0_valid, a_rsp0_equal, a_rsp1_valid, a_rsp1_equal;
    logic [31:0] a_rsp0_out, a_rsp1_out;
    logic [3:0]  a_alu_op;
    logic [31:0] a_alu_in1, a_alu_in2, a_alu_out;
    logic        a_alu_equal;

    // ---------------- fixed-priority instance ----------------
    logic        b_req0_ready, b_req1_ready;
    logic        b_rsp0_valid, b_rsp0_equal, b_rsp1_valid, b_rsp1_equal;
    logic [31:0] b_rsp0_out, b_rsp1_out;
    logic [3:0]  b_alu_op;
    logic [31:0] b_alu_in1, b_alu_in2, b_alu_out;
    logic        b_alu_equal;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_SLT:  return {31'd0, $signed(x) < $signed(y)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign a_alu_out   = alu_f(a_alu_op, a_alu_in1, a_alu_in2);
    assign a_alu_equal = (a_alu_in1 == a_alu_in2);
    assign b_alu_out   = alu_f(b_alu_op, b_alu_in1, b_alu_in2);
    assign b_alu_equal = (b_alu_in1 == b_alu_in2);

    alu_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_op(req0_op),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_op(req1_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .rsp0_valid(a_rsp0_valid), .rsp0_out(a_rsp0_out), .rsp0_equal(a_rsp0_equal),
        .rsp1_valid(a_rsp1_valid), .rsp1_out(a_rsp1_out), .rsp1_equal(a_rsp1_equal),
        .alu_op(a_alu_op), .alu_in1(a_alu_in1), .alu_in2(a_alu_in2),
        .alu_out(a_alu_out), .alu_equal(a_alu_equal)
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_op(req0_op),
        .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_op(req1_op),
        .req1_in1(req1_in1), .req1_in2(req1_in2),
        .rsp0_valid(b_rsp0_valid), .rsp0_out(b_rsp0_out), .rsp0_equal(b_rsp0_equal),
        .rsp1_valid(b_rsp1_valid), .rsp1_out(b_rsp1_out), .rsp1_equal(b_rsp1_equal),
        .alu_op(b_alu_op), .alu_in1(b_alu_in1), .alu_in2(b_alu_in2),
        .alu_out(b_alu_out), .alu_equal(b_alu_equal)
    );

    // ---------------- scoreboard ----------------
    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];
    logic [31:0] exp_id_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        req0_valid = v;
        req0_op    = op;
        req0_in1   = x;
        req0_in2   = y;
    endtask

    task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        req1_valid = v;
        req1_op    = op;
        req1_in1   = x;
        req1_in2   = y;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Alternation tables: req0 issues ADD, req1 issues SUB.
    logic [31:0] t0_a[3];
    logic [31:0] t0_b[3];
    logic [31:0] t0_e[3];
    logic [31:0] t1_a[3];
    logic [31:0] t1_b[3];
    logic [31:0] t1_e[3];

    initial begin
        int n0;
        int n1;
        int i0;
        int i1;
        logic [31:0] eid;
        logic [31:0] ev;

        vectors     = 0;
        miscompares = 0;
        t0_a = '{32'd1, 32'd2, 32'd3};
        t0_b = '{32'd10, 32'd20, 32'd30};
        t0_e = '{32'd11, 32'd22, 32'd33};
        t1_a = '{32'd100, 32'd200, 32'd300};
        t1_b = '{32'd1, 32'd2, 32'd3};
        t1_e = '{32'd99, 32'd198, 32'd297};

        // ---- reset state ----
        rst_n = 1'b0;
        drive0(1'b1, OP_ADD, 32'd9, 32'd9);
        drive1(1'b1, OP_ADD, 32'd9, 32'd9);
        tick();
        tick();
        check_eq("rst_req0_ready", 32'(a_req0_ready), 32'd0);
        check_eq("rst_req1_ready", 32'(a_req1_ready), 32'd0);
        check_eq("rst_fp_req0_ready", 32'(b_req0_ready), 32'd0);
        check_eq("rst_rsp0_valid", 32'(a_rsp0_valid), 32'd0);
        check_eq("rst_rsp1_valid", 32'(a_rsp1_valid), 32'd0);
        check_eq("rst_rsp0_out", a_rsp0_out, 32'd0);
        check_eq("rst_rsp1_equal", 32'(a_rsp1_equal), 32'd0);
        check_eq("rst_alu_op", 32'(a_alu_op), 32'd0);
        check_eq("rst_alu_in1", a_alu_in1, 32'd0);
        check_eq("rst_alu_in2", a_alu_in2, 32'd0);

        // ---- round-robin alternation, first edge after release ----
        rst_n = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                i0 = (n0 < 3) ? n0 : 2;
                i1 = (n1 < 3) ? n1 : 2;
                drive0(1'b1, OP_ADD, t0_a[i0], t0_b[i0]);
                drive1(1'b1, OP_SUB, t1_a[i1], t1_b[i1]);
                #1;
                check_eq("rr_req0_ready", 32'(a_req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
                check_eq("rr_req1_ready", 32'(a_req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
            if (exp_q.size() > 0) begin
                eid = exp_id_q.pop_front();
                ev  = exp_q.pop_front();
                if (eid == 0) begin
                    check_eq("rr_rsp0_valid", 32'(a_rsp0_valid), 32'd1);
                    check_eq("rr_rsp1_idle", 32'(a_rsp1_valid), 32'd0);
                    check_eq("rr_rsp0_out", a_rsp0_out, ev);
                end else begin
                    check_eq("rr_rsp1_valid", 32'(a_rsp1_valid), 32'd1);
                    check_eq("rr_rsp0_idle", 32'(a_rsp0_valid), 32'd0);
                    check_eq("rr_rsp1_out", a_rsp1_out, ev);
                end
            end
            if (i < 6) begin
                if (i % 2 == 0) begin
                    exp_id_q.push_back(32'd0);
                    exp_q.push_back(t0_e[n0]);
                    n0++;
                end else begin
                    exp_id_q.push_back(32'd1);
                    exp_q.push_back(t1_e[n1]);
                    n1++;
                end
            end
        end
        tick();
        check_eq("rr_drain_rsp0", 32'(a_rsp0_valid), 32'd0);
        check_eq("rr_drain_rsp1", 32'(a_rsp1_valid), 32'd0);

        // ---- req0 alone: ADD 5+7 ----
        drive0(1'b1, OP_ADD, 32'd5, 32'd7);
        #1;
        check_eq("add_req0_ready", 32'(a_req0_ready), 32'd1);
        check_eq("add_req1_ready", 32'(a_req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check_eq("add_alu_op", 32'(a_alu_op), 32'(OP_ADD));
        check_eq("add_alu_in1", a_alu_in1, 32'd5);
        check_eq("add_early_rsp0", 32'(a_rsp0_valid), 32'd0);
        tick();
        check_eq("add_rsp0_valid", 32'(a_rsp0_valid), 32'd1);
        check_eq("add_rsp0_out", a_rsp0_out, 32'd12);
        check_eq("add_rsp0_equal", 32'(a_rsp0_equal), 32'd0);
        check_eq("add_rsp1_valid", 32'(a_rsp1_valid), 32'd0);
        tick();
        check_eq("add_pulse_end", 32'(a_rsp0_valid), 32'd0);
        check_eq("idle_alu_in1_hold", a_alu_in1, 32'd5);
        check_eq("idle_rsp0_hold", a_rsp0_out, 32'd12);

        // ---- req1 back-to-back: SUB 3-3 then SLT -1<1 ----
        drive1(1'b1, OP_SUB, 32'd3, 32'd3);
        #1;
        check_eq("sub_req1_ready", 32'(a_req1_ready), 32'd1);
        tick();
        drive1(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        #1;
        check_eq("slt_req1_ready", 32'(a_req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_eq("sub_rsp1_valid", 32'(a_rsp1_valid), 32'd1);
        check_eq("sub_rsp1_out", a_rsp1_out, 32'd0);
        check_eq("sub_rsp1_equal", 32'(a_rsp1_equal), 32'd1);
        tick();
        check_eq("slt_rsp1_valid", 32'(a_rsp1_valid), 32'd1);
        check_eq("slt_rsp1_out", a_rsp1_out, 32'd1);
        check_eq("slt_rsp1_equal", 32'(a_rsp1_equal), 32'd0);
        check_eq("slt_rsp0_hold", a_rsp0_out, 32'd12);

        // ---- req1 granted last, then req0 alone; then contention goes to req1 ----
        drive0(1'b1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
        #1;
        check_eq("starve_req0_ready", 32'(a_req0_ready), 32'd1);
        tick();
        drive1(1'b1, OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        #1;
        check_eq("starve_req1_ready", 32'(a_req1_ready), 32'd1);
        check_eq("starve_req0_wait", 32'(a_req0_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check_eq("or_rsp0_out", a_rsp0_out, 32'h0000_00FF);
        tick();
        check_eq("and_rsp1_out", a_rsp1_out, 32'h0F00_0F00);
        idle(2);

        // ---- fixed priority: req1 stalls until req0 drops ----
        drive0(1'b1, OP_ADD, 32'd1, 32'd1);
        drive1(1'b1, OP_ADD, 32'd2, 32'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("fp_req0_ready", 32'(b_req0_ready), 32'd1);
            check_eq("fp_req1_stall", 32'(b_req1_ready), 32'd0);
            tick();
        end
        req0_valid = 1'b0;
        #1;
        check_eq("fp_req1_ready", 32'(b_req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check_eq("fp_rsp1_valid", 32'(b_rsp1_valid), 32'd1);
        check_eq("fp_rsp1_out", b_rsp1_out, 32'd4);
        idle(2);

        // ---- undefined opcode is forwarded unchanged ----
        drive0(1'b1, 4'hF, 32'd4, 32'd4);
        tick();
        req0_valid = 1'b0;
        check_eq("undef_alu_op", 32'(a_alu_op), 32'h0000_000F);
        tick();
        check_eq("undef_rsp0_out", a_rsp0_out, 32'hDEAD_BEEF);
        check_eq("undef_rsp0_equal", 32'(a_rsp0_equal), 32'd1);
        idle(1);

        // ---- reset with an operation in the issue stage ----
        drive0(1'b1, OP_ADD, 32'd2, 32'd2);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        drive1(1'b1, OP_XOR, 32'h0000_00F0, 32'h0000_00FF);
        #1;
        check_eq("mid_rst_alu_op", 32'(a_alu_op), 32'd0);
        check_eq("mid_rst_alu_in1", a_alu_in1, 32'd0);
        check_eq("mid_rst_rsp0_out", a_rsp0_out, 32'd0);
        check_eq("mid_rst_rsp0_equal", 32'(a_rsp0_equal), 32'd0);
        check_eq("mid_rst_req1_ready", 32'(a_req1_ready), 32'd0);
        tick();
        check_eq("mid_rst_rsp0_valid", 32'(a_rsp0_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_req1_ready", 32'(a_req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_eq("post_rst_no_rsp0", 32'(a_rsp0_valid), 32'd0);
        check_eq("post_rst_no_rsp1", 32'(a_rsp1_valid), 32'd0);
        tick();
        check_eq("post_rst_rsp1_valid", 32'(a_rsp1_valid), 32'd1);
        check_eq("post_rst_rsp1_out", a_rsp1_out, 32'h0000_000F);
        check_eq("post_rst_rsp0_quiet", 32'(a_rsp0_valid), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
